pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the EN/flush pair of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) plus PC enable and PC source select.
- Resolves load-use hazards, taken branches, traps/mret and multi-cycle data-memory waits, with a watchdog that converts a hung memory access into a bus-error trap.
- Sits beside the datapath and is fed from the ID, EX and MEM stage latch outputs.

Parameters:
- MEM_TIMEOUT, 16, MEM_WAIT cycles before bus error (≥2).
- CNT_W, 32, width of stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- rs1_addr_ID  in  5  ID-stage source register 1
- rs2_addr_ID  in  5  ID-stage source register 2
- rs1_used_ID  in  1  ID instruction reads rs1
- rs2_used_ID  in  1  ID instruction reads rs2
- rd_EX  in  5  EX-stage destination
- mem_r_EX  in  1  EX instruction is a load
- branch_taken_EX  in  1  EX branch/jump redirects
- mem_req_MEM  in  1  MEM stage accessing data memory
- mem_ready  in  1  data memory completes access this cycle
- trap_MEM  in  1  exception committing in MEM (exp_vector_MEM≠0)
- mret_MEM  in  1  mret committing in MEM
- pc_en  out  1  PC register enable
- en_IF_ID, flush_IF_ID  out  1 each
- en_ID_EX, flush_ID_EX  out  1 each
- en_EX_MEM, flush_EX_MEM  out  1 each
- en_MEM_WB, flush_MEM_WB  out  1 each
- pc_sel  out  2  0=PC+4, 1=branch target, 2=trap vector, 3=mepc
- bus_err  out  1  one-cycle pulse, memory timeout
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset

Behaviour:
- States: RUN, MEM_WAIT, ERR_FLUSH. Control outputs are combinational from state and inputs. State, watchdog and stall_cnt are registered.
- Reset (rst=0 at a clk edge):
  - state←RUN, watchdog←0, stall_cnt←0.
  - While rst=0, all en/flush outputs, pc_en, pc_sel and bus_err are forced 0.
  - Reset mid-MEM_WAIT abandons the wait with no bus_err.
- Default in RUN: all en=1, all flush=0, pc_sel=0.
- RUN priority, highest first:
  1. trap_MEM or mret_MEM:
     - pc_sel=2 (trap) or 3 (mret); trap wins if both.
     - flush_IF_ID=flush_ID_EX=flush_EX_MEM=1, all en=1.
     - MEM/WB not flushed; the trapping instruction itself is suppressed via exp_vector downstream.
  2. mem_req_MEM && !mem_ready:
     - All en=0 and pc_en=0 (full freeze), flush=0.
     - Next state MEM_WAIT, watchdog←1.
  3. branch_taken_EX:
     - pc_sel=1, flush_IF_ID=flush_ID_EX=1, all en=1.
  4. Load-use:
     - Condition: mem_r_EX && rd_EX≠0 && ((rs1_used_ID && rs1_addr_ID==rd_EX) || (rs2_used_ID && rs2_addr_ID==rd_EX)).
     - Response: pc_en=0, en_IF_ID=0, en_ID_EX=1 with flush_ID_EX=1 (bubble), downstream en=1.
     - Lasts exactly one cycle, because the load advances to MEM.
- Branch and load-use never coincide, since a load is not a branch. Branch is still listed above load-use for determinism.
- MEM_WAIT:
  - Outputs are the full freeze.
  - If mem_ready=1: same cycle outputs become RUN defaults with priorities re-evaluated (trap/branch/load-use may apply); next state RUN, watchdog←0.
  - Else if watchdog==MEM_TIMEOUT-1: next state ERR_FLUSH.
  - Else watchdog←watchdog+1.
  - trap_MEM/mret_MEM are ignored while waiting; inputs are frozen by construction.
- ERR_FLUSH (exactly one cycle):
  - bus_err=1, pc_sel=2.
  - All four flush=1, all en=1, pc_en=1.
  - Next state RUN.
- stall_cnt increments by 1 on each non-reset cycle where pc_en=0 and wraps modulo 2^CNT_W.
- A flush takes effect only when its latch's en=1; the controller never asserts flush with en=0 on the same latch.

Test Plan:
- Reset: hold rst=0 for 3 clocks with random inputs → all control outputs 0, stall_cnt=0. Release with idle inputs → pc_en=1, all en=1, pc_sel=0.
- Load-use: mem_r_EX=1, rd_EX=5, rs2_used_ID=1, rs2_addr_ID=5 for one cycle → pc_en=0, en_IF_ID=0, flush_ID_EX=1, stall_cnt=1. Repeat with rd_EX=0 → no stall.
- Taken branch: branch_taken_EX=1 → pc_sel=1, flush_IF_ID=flush_ID_EX=1, pc_en=1, stall_cnt unchanged.
- Memory wait: mem_req_MEM=1, mem_ready=0 for 4 cycles, then 1 → all en=0 for 4 cycles, RUN outputs on the 5th, stall_cnt=4, bus_err never asserted.
- Timeout: MEM_TIMEOUT=16, mem_ready held 0 → full freeze for 16 cycles, then one cycle with bus_err=1, pc_sel=2, all flushes=1, then RUN.
- Trap vs branch: trap_MEM=1, mret_MEM=1, branch_taken_EX=1 together → pc_sel=2, flush IF_ID/ID_EX/EX_MEM=1, flush_MEM_WB=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, trap/mret,
// data-memory wait handling and a watchdog that turns a hung access into a bus error.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addr_ID,
    input  logic [4:0]       rs2_addr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             mem_r_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    input  logic             trap_MEM,
    input  logic             mret_MEM,
    output logic             pc_en,
    output logic             en_IF_ID,
    output logic             flush_IF_ID,
    output logic             en_ID_EX,
    output logic             flush_ID_EX,
    output logic             en_EX_MEM,
    output logic             flush_EX_MEM,
    output logic             en_MEM_WB,
    output logic             flush_MEM_WB,
    output logic [1:0]       pc_sel,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WD_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        ERR_FLUSH = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WD_W-1:0]  wd_r;
    logic [WD_W-1:0]  wd_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             load_use_s;
    logic             run_eval_s;

    assign load_use_s = mem_r_EX && (rd_EX != 5'd0) &&
                        ((rs1_used_ID && (rs1_addr_ID == rd_EX)) ||
                         (rs2_used_ID && (rs2_addr_ID == rd_EX)));

    // A completing wait re-enters the normal RUN priority resolution in the same cycle
    assign run_eval_s = (state_r == RUN) || ((state_r == MEM_WAIT) && mem_ready);

    assign stall_cnt = stall_cnt_r;

    // Next-state, watchdog update and combinational pipeline controls
    always_comb begin
        state_nxt_s  = RUN;
        wd_nxt_s     = {WD_W{1'b0}};
        pc_en        = 1'b0;
        en_IF_ID     = 1'b0;
        flush_IF_ID  = 1'b0;
        en_ID_EX     = 1'b0;
        flush_ID_EX  = 1'b0;
        en_EX_MEM    = 1'b0;
        flush_EX_MEM = 1'b0;
        en_MEM_WB    = 1'b0;
        flush_MEM_WB = 1'b0;
        pc_sel       = 2'd0;
        bus_err      = 1'b0;
        if (!rst) begin
            state_nxt_s = RUN;
        end else if (run_eval_s) begin
            pc_en     = 1'b1;
            en_IF_ID  = 1'b1;
            en_ID_EX  = 1'b1;
            en_EX_MEM = 1'b1;
            en_MEM_WB = 1'b1;
            if (trap_MEM || mret_MEM) begin
                // MEM/WB keeps flowing; the trapping instruction is squashed downstream
                pc_sel       = trap_MEM ? 2'd2 : 2'd3;
                flush_IF_ID  = 1'b1;
                flush_ID_EX  = 1'b1;
                flush_EX_MEM = 1'b1;
            end else if (mem_req_MEM && !mem_ready) begin
                pc_en       = 1'b0;
                en_IF_ID    = 1'b0;
                en_ID_EX    = 1'b0;
                en_EX_MEM   = 1'b0;
                en_MEM_WB   = 1'b0;
                state_nxt_s = MEM_WAIT;
                wd_nxt_s    = {{(WD_W-1){1'b0}}, 1'b1};
            end else if (branch_taken_EX) begin
                pc_sel      = 2'd1;
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end else if (load_use_s) begin
                pc_en       = 1'b0;
                en_IF_ID    = 1'b0;
                flush_ID_EX = 1'b1;
            end else begin
                pc_sel = 2'd0;
            end
        end else if (state_r == MEM_WAIT) begin
            if (wd_r == WD_LAST) begin
                state_nxt_s = ERR_FLUSH;
                wd_nxt_s    = {WD_W{1'b0}};
            end else begin
                state_nxt_s = MEM_WAIT;
                wd_nxt_s    = wd_r + WD_W'(1);
            end
        end else if (state_r == ERR_FLUSH) begin
            pc_en        = 1'b1;
            en_IF_ID     = 1'b1;
            en_ID_EX     = 1'b1;
            en_EX_MEM    = 1'b1;
            en_MEM_WB    = 1'b1;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
            pc_sel       = 2'd2;
            bus_err      = 1'b1;
        end else begin
            state_nxt_s = RUN;
        end
    end

    // State and watchdog registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= RUN;
            wd_r    <= {WD_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wd_r    <= wd_nxt_s;
        end
    end

    // Stall-cycle counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_en) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; expected controls are queued by the
// driver and checked by an independent monitor on the falling edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs1_addr_ID, rs2_addr_ID, rd_EX;
    logic        rs1_used_ID, rs2_used_ID, mem_r_EX, branch_taken_EX;
    logic        mem_req_MEM, mem_ready, trap_MEM, mret_MEM;
    logic        pc_en, en_IF_ID, flush_IF_ID, en_ID_EX, flush_ID_EX;
    logic        en_EX_MEM, flush_EX_MEM, en_MEM_WB, flush_MEM_WB, bus_err;
    logic [1:0]  pc_sel;
    logic [31:0] stall_cnt;

    // {pc_en, en_IF_ID, fl_IF_ID, en_ID_EX, fl_ID_EX, en_EX_MEM, fl_EX_MEM, en_MEM_WB, fl_MEM_WB, pc_sel, bus_err}
    localparam logic [11:0] V_ZERO = 12'b0_0_0_0_0_0_0_0_0_00_0;
    localparam logic [11:0] V_RUN  = 12'b1_1_0_1_0_1_0_1_0_00_0;
    localparam logic [11:0] V_LU   = 12'b0_0_0_1_1_1_0_1_0_00_0;
    localparam logic [11:0] V_BR   = 12'b1_1_1_1_1_1_0_1_0_01_0;
    localparam logic [11:0] V_FRZ  = 12'b0_0_0_0_0_0_0_0_0_00_0;
    localparam logic [11:0] V_TRAP = 12'b1_1_1_1_1_1_1_1_0_10_0;
    localparam logic [11:0] V_MRET = 12'b1_1_1_1_1_1_1_1_0_11_0;
    localparam logic [11:0] V_ERR  = 12'b1_1_1_1_1_1_1_1_1_10_1;

    typedef struct packed {
        logic [11:0] ctl;
        logic [31:0] cnt;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          vid = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [11:0] act;

    assign act = {pc_en, en_IF_ID, flush_IF_ID, en_ID_EX, flush_ID_EX, en_EX_MEM,
                  flush_EX_MEM, en_MEM_WB, flush_MEM_WB, pc_sel, bus_err};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .mem_r_EX(mem_r_EX), .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
        .trap_MEM(trap_MEM), .mret_MEM(mret_MEM),
        .pc_en(pc_en), .en_IF_ID(en_IF_ID), .flush_IF_ID(flush_IF_ID),
        .en_ID_EX(en_ID_EX), .flush_ID_EX(flush_ID_EX),
        .en_EX_MEM(en_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
        .en_MEM_WB(en_MEM_WB), .flush_MEM_WB(flush_MEM_WB),
        .pc_sel(pc_sel), .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rs1_addr_ID = 5'd0; rs2_addr_ID = 5'd0; rd_EX = 5'd0;
        rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; mem_r_EX = 1'b0;
        branch_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
        trap_MEM = 1'b0; mret_MEM = 1'b0;
    endtask

    // Queue the expectation for the current cycle, update the count model, advance a clock.
    task automatic step(input logic [11:0] ctl);
        exp_t e;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        e.id  = vid;
        vid++;
        sb_q.push_back(e);
        if (!rst) exp_cnt = 32'd0;
        else if (!ctl[11]) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle, compare one queued entry per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (act !== e.ctl || stall_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL vec%0d: ctl got %b want %b, stall_cnt got %0d want %0d",
                             e.id, act, e.ctl, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            {rs1_addr_ID, rs2_addr_ID, rd_EX} = 15'($urandom);
            {rs1_used_ID, rs2_used_ID, mem_r_EX, branch_taken_EX} = 4'($urandom);
            {mem_req_MEM, mem_ready, trap_MEM, mret_MEM} = 4'($urandom);
            step(V_ZERO);
        end
        rst = 1'b1;
        idle();
        step(V_RUN);
        // Load-use on rs2
        mem_r_EX = 1'b1; rd_EX = 5'd5; rs2_used_ID = 1'b1; rs2_addr_ID = 5'd5;
        step(V_LU);
        idle();
        step(V_RUN);
        // rd_EX = x0 never stalls
        mem_r_EX = 1'b1; rd_EX = 5'd0; rs2_used_ID = 1'b1; rs2_addr_ID = 5'd0;
        step(V_RUN);
        // rs1 matches but is not used
        idle();
        mem_r_EX = 1'b1; rd_EX = 5'd7; rs1_addr_ID = 5'd7; rs1_used_ID = 1'b0;
        step(V_RUN);
        rs1_used_ID = 1'b1;
        step(V_LU);
        idle();
        branch_taken_EX = 1'b1;
        step(V_BR);
        idle();
        step(V_RUN);
        // Four-cycle memory wait
        mem_req_MEM = 1'b1;
        for (int i = 0; i < 4; i++) step(V_FRZ);
        mem_ready = 1'b1;
        step(V_RUN);
        // Wait completing together with a taken branch
        idle();
        mem_req_MEM = 1'b1;
        step(V_FRZ);
        mem_ready = 1'b1; branch_taken_EX = 1'b1;
        step(V_BR);
        // Watchdog timeout; trap is ignored while waiting
        idle();
        mem_req_MEM = 1'b1;
        for (int i = 0; i < 16; i++) begin
            trap_MEM = (i == 5);
            step(V_FRZ);
        end
        trap_MEM = 1'b0;
        step(V_ERR);
        idle();
        step(V_RUN);
        // Trap beats mret and branch; mret alone
        trap_MEM = 1'b1; mret_MEM = 1'b1; branch_taken_EX = 1'b1;
        step(V_TRAP);
        idle();
        mret_MEM = 1'b1;
        step(V_MRET);
        // Reset in the middle of a wait: no bus error afterwards
        idle();
        mem_req_MEM = 1'b1;
        step(V_FRZ);
        step(V_FRZ);
        rst = 1'b0;
        step(V_ZERO);
        rst = 1'b1;
        idle();
        for (int i = 0; i < 20; i++) step(V_RUN);
        // Fresh wait after reset resolves normally
        mem_req_MEM = 1'b1;
        step(V_FRZ);
        mem_ready = 1'b1;
        step(V_RUN);
        idle();
        @(negedge clk);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
